// File: rtl/mod_blkbuf.sv
// mod_blkbuf: DEPTH-entry FIFO of N-word blocks between the AES key/data input
// interface and the round datapath. Blocks are loaded either whole (parallel
// beat) or one word per beat (word-serial), where they are assembled internally
// before being pushed.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous clear of FIFO and any partial assembly
//   in_valid   producer beat valid
//   in_ready   beat accepted this cycle
//   in_mode    0 = parallel block beat (i), 1 = word-serial beat (i_word)
//   i          parallel block data
//   i_word     serial word data
//   out_valid  head block available
//   out_ready  consumer takes head block
//   o          head block data (registered storage, no path from i)
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored blocks
//   asm_busy   serial assembly in progress
module mod_blkbuf #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [N-1:0][W-1:0]           i,
  input  logic [W-1:0]                  i_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0][W-1:0]           o,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          asm_busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][W-1:0] blk_t;

  blk_t          mem [DEPTH];
  blk_t          asm_q;
  blk_t          asm_next;
  blk_t          push_data;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] idx;
  logic          accept;
  logic          push;
  logic          pop;
  logic          last_word;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign asm_busy  = (idx != '0);

  // A parallel beat waits for an unfinished serial assembly rather than
  // aborting it.
  assign in_ready  = !full && !(!in_mode && asm_busy);
  assign accept    = in_valid && in_ready;
  assign last_word = (idx == IW'(N - 1));
  assign push      = accept && (!in_mode || last_word);
  assign pop       = out_valid && out_ready;
  assign o         = mem[rd_ptr];

  // Assembly including the word arriving this cycle, so the final serial
  // word lands in storage on the same edge it is accepted.
  always_comb begin
    asm_next      = asm_q;
    asm_next[idx] = i_word;
  end

  assign push_data = in_mode ? asm_next : i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      asm_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      count  <= '0;
    end else if (flush) begin
      // Storage is left intact; only bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      count  <= '0;
    end else begin
      if (accept && in_mode) begin
        asm_q <= asm_next;
        idx   <= last_word ? '0 : idx + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
